control_sequencer: RTL and testbench

Microprogram sequencer sitting directly downstream of the instruction-to-state encoder in the control unit. Holds the 7-bit current control state that addresses the control ROM and computes the next state each cycle from four sources: the ROM's next-state mode field, the encoder's `State_Sel`, the ROM's jump-target field, and condition/memory-handshake inputs. Adds a memory-wait watchdog and an illegal-opcode flag so the datapath never hangs silently.

---
 rtl/control_sequencer.sv | 98 +++++++++
 tb/tb_control_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microprogram sequencer: selects the next control-ROM state from the ROM mode
// field, the decoder, jump targets, and conditions, with a MOC watchdog.
module control_sequencer #(
  parameter int unsigned         STATE_W     = 7,
  parameter logic [STATE_W-1:0]  RESET_STATE = 7'd0,
  parameter logic [STATE_W-1:0]  FETCH_STATE = 7'd1,
  parameter logic [STATE_W-1:0]  TRAP_STATE  = 7'd127,
  parameter int unsigned         MOC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] State_Sel,
  input  logic [2:0]         NS_Sel,
  input  logic [STATE_W-1:0] CR_Addr,
  input  logic               Cond,
  input  logic               Inv,
  input  logic               MOC,
  output logic [STATE_W-1:0] State,
  output logic               Illegal,
  output logic               Timeout
);

  localparam int unsigned        CNT_W    = $clog2(MOC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    NS_INC      = 3'd0,
    NS_DECODE   = 3'd1,
    NS_JUMP     = 3'd2,
    NS_COND     = 3'd3,
    NS_WAIT_MOC = 3'd4,
    NS_FETCH    = 3'd5
  } ns_mode_e;

  ns_mode_e           ns_mode;
  logic [STATE_W-1:0] state_q, state_d, state_inc;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;

  assign ns_mode   = ns_mode_e'(NS_Sel);
  assign state_inc = state_q + STATE_W'(1);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    illegal_d  = 1'b0;
    timeout_d  = timeout_q;
    // The trap state holds until reset, whatever the ROM presents.
    if (state_q != TRAP_STATE) begin
      case (ns_mode)
        NS_INC:    state_d = state_inc;
        NS_DECODE: begin
          if (State_Sel != '0) begin
            state_d = State_Sel;
          end else begin
            state_d   = FETCH_STATE;
            illegal_d = 1'b1;
          end
        end
        NS_JUMP:   state_d = CR_Addr;
        NS_COND:   state_d = (Cond ^ Inv) ? CR_Addr : state_inc;
        NS_WAIT_MOC: begin
          // A MOC arriving on the last allowed cycle still wins over the trap.
          if (MOC) begin
            state_d = state_inc;
          end else if (wait_cnt_q == CNT_LAST) begin
            state_d   = TRAP_STATE;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        NS_FETCH:  state_d = FETCH_STATE;
        default:   state_d = TRAP_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign State   = state_q;
  assign Illegal = illegal_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table plus watchdog, trap and
// wraparound sequences.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] State_Sel = '0;
  logic [2:0] NS_Sel = '0;
  logic [6:0] CR_Addr = '0;
  logic       Cond = 1'b0, Inv = 1'b0, MOC = 1'b0;
  logic [6:0] State, State_w;
  logic       Illegal, Timeout, Illegal_w, Timeout_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_sequencer #(
    .STATE_W(7), .RESET_STATE(7'd0), .FETCH_STATE(7'd1),
    .TRAP_STATE(7'd127), .MOC_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .State_Sel(State_Sel), .NS_Sel(NS_Sel),
    .CR_Addr(CR_Addr), .Cond(Cond), .Inv(Inv), .MOC(MOC),
    .State(State), .Illegal(Illegal), .Timeout(Timeout)
  );

  // Trap moved off 127 so the INC wraparound from 127 can be observed.
  control_sequencer #(
    .STATE_W(7), .RESET_STATE(7'd0), .FETCH_STATE(7'd1),
    .TRAP_STATE(7'd100), .MOC_TIMEOUT(15)
  ) dut_wrap (
    .clk(clk), .reset(reset), .State_Sel(State_Sel), .NS_Sel(NS_Sel),
    .CR_Addr(CR_Addr), .Cond(Cond), .Inv(Inv), .MOC(MOC),
    .State(State_w), .Illegal(Illegal_w), .Timeout(Timeout_w)
  );

  typedef struct {
    logic       rst;
    logic [2:0] ns;
    logic [6:0] sel;
    logic [6:0] cr;
    logic       cond;
    logic       inv;
    logic       moc;
    logic [6:0] e_state;
    logic       e_ill;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [2:0] ns,
                              input logic [6:0] sel, input logic [6:0] cr,
                              input logic cond, input logic inv, input logic moc,
                              input logic [6:0] e_state, input logic e_ill,
                              input logic e_to);
    vec_t v;
    v.rst = rst; v.ns = ns; v.sel = sel; v.cr = cr;
    v.cond = cond; v.inv = inv; v.moc = moc;
    v.e_state = e_state; v.e_ill = e_ill; v.e_to = e_to;
    return v;
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and leave the outputs settled.
  task automatic step(input logic rst, input logic [2:0] ns, input logic [6:0] sel,
                      input logic [6:0] cr, input logic cond, input logic inv,
                      input logic moc);
    reset = rst; NS_Sel = ns; State_Sel = sel; CR_Addr = cr;
    Cond = cond; Inv = inv; MOC = moc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [6:0] e_state,
                         input logic e_ill, input logic e_to);
    chk({name, "_state"}, State, e_state);
    chk({name, "_illegal"}, {6'd0, Illegal}, {6'd0, e_ill});
    chk({name, "_timeout"}, {6'd0, Timeout}, {6'd0, e_to});
  endtask

  initial begin
    //               rst  ns    sel   cr     c  i  m   state  ill to
    vecs.push_back(mk(1, 3'd0, 7'd0, 7'd0,  0, 0, 0, 7'd0,   0, 0));
    vecs.push_back(mk(0, 3'd0, 7'd0, 7'd0,  0, 0, 0, 7'd1,   0, 0));
    vecs.push_back(mk(0, 3'd0, 7'd0, 7'd0,  0, 0, 0, 7'd2,   0, 0));
    vecs.push_back(mk(0, 3'd0, 7'd0, 7'd0,  0, 0, 0, 7'd3,   0, 0));
    vecs.push_back(mk(0, 3'd2, 7'd0, 7'd2,  0, 0, 0, 7'd2,   0, 0));
    vecs.push_back(mk(0, 3'd1, 7'd6, 7'd0,  0, 0, 0, 7'd6,   0, 0));
    vecs.push_back(mk(0, 3'd2, 7'd0, 7'd2,  0, 0, 0, 7'd2,   0, 0));
    vecs.push_back(mk(0, 3'd1, 7'd0, 7'd0,  0, 0, 0, 7'd1,   1, 0));
    vecs.push_back(mk(0, 3'd0, 7'd0, 7'd0,  0, 0, 0, 7'd2,   0, 0));
    vecs.push_back(mk(0, 3'd3, 7'd0, 7'd40, 1, 0, 0, 7'd40,  0, 0));
    vecs.push_back(mk(0, 3'd3, 7'd0, 7'd40, 1, 1, 0, 7'd41,  0, 0));
    vecs.push_back(mk(0, 3'd3, 7'd0, 7'd40, 0, 1, 0, 7'd40,  0, 0));
    vecs.push_back(mk(0, 3'd3, 7'd0, 7'd40, 0, 0, 0, 7'd41,  0, 0));
    vecs.push_back(mk(0, 3'd5, 7'd0, 7'd0,  0, 0, 0, 7'd1,   0, 0));
    vecs.push_back(mk(0, 3'd2, 7'd0, 7'd13, 0, 0, 0, 7'd13,  0, 0));
    vecs.push_back(mk(0, 3'd4, 7'd0, 7'd0,  0, 0, 0, 7'd13,  0, 0));
    vecs.push_back(mk(0, 3'd4, 7'd0, 7'd0,  0, 0, 0, 7'd13,  0, 0));
    vecs.push_back(mk(0, 3'd4, 7'd0, 7'd0,  0, 0, 0, 7'd13,  0, 0));
    vecs.push_back(mk(0, 3'd4, 7'd0, 7'd0,  0, 0, 0, 7'd13,  0, 0));
    vecs.push_back(mk(0, 3'd4, 7'd0, 7'd0,  0, 0, 1, 7'd14,  0, 0));
    vecs.push_back(mk(0, 3'd2, 7'd0, 7'd5,  0, 0, 0, 7'd5,   0, 0));
    vecs.push_back(mk(0, 3'd6, 7'd0, 7'd0,  0, 0, 0, 7'd127, 0, 0));
    vecs.push_back(mk(0, 3'd1, 7'd6, 7'd0,  0, 0, 0, 7'd127, 0, 0));
    vecs.push_back(mk(0, 3'd1, 7'd0, 7'd0,  0, 0, 0, 7'd127, 0, 0));
    vecs.push_back(mk(1, 3'd1, 7'd6, 7'd0,  0, 0, 0, 7'd0,   0, 0));
    vecs.push_back(mk(0, 3'd7, 7'd0, 7'd0,  0, 0, 0, 7'd127, 0, 0));
    vecs.push_back(mk(1, 3'd0, 7'd0, 7'd0,  0, 0, 0, 7'd0,   0, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ns, vecs[i].sel, vecs[i].cr,
           vecs[i].cond, vecs[i].inv, vecs[i].moc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_ill, vecs[i].e_to);
    end

    // MOC arriving on the 15th wait cycle advances without trapping.
    step(0, 3'd2, 7'd0, 7'd13, 0, 0, 0);
    for (int unsigned k = 0; k < 14; k++) begin
      step(0, 3'd4, 7'd0, 7'd0, 0, 0, 0);
      chk($sformatf("late_moc_hold%0d", k), State, 7'd13);
    end
    step(0, 3'd4, 7'd0, 7'd0, 0, 0, 1);
    chk_all("late_moc_advance", 7'd14, 0, 0);

    // MOC stuck low: 15 cycles in 13, then trap with Timeout.
    step(0, 3'd2, 7'd0, 7'd13, 0, 0, 0);
    for (int unsigned k = 0; k < 14; k++) begin
      step(0, 3'd4, 7'd0, 7'd0, 0, 0, 0);
      chk($sformatf("stuck_hold%0d", k), State, 7'd13);
      chk($sformatf("stuck_to%0d", k), {6'd0, Timeout}, 7'd0);
    end
    step(0, 3'd4, 7'd0, 7'd0, 0, 0, 0);
    chk_all("stuck_trap", 7'd127, 0, 1);
    step(0, 3'd0, 7'd0, 7'd0, 0, 0, 1);
    chk_all("trap_inc", 7'd127, 0, 1);
    step(0, 3'd1, 7'd0, 7'd0, 0, 0, 0);
    chk_all("trap_decode_illegal", 7'd127, 0, 1);
    step(0, 3'd2, 7'd0, 7'd9, 0, 0, 0);
    chk_all("trap_jump", 7'd127, 0, 1);
    step(1, 3'd4, 7'd0, 7'd0, 0, 0, 0);
    chk_all("trap_reset", 7'd0, 0, 0);

    // Reset mid-wait must clear the watchdog so the next wait gets its full budget.
    step(0, 3'd2, 7'd0, 7'd20, 0, 0, 0);
    for (int unsigned k = 0; k < 10; k++) step(0, 3'd4, 7'd0, 7'd0, 0, 0, 0);
    step(1, 3'd4, 7'd0, 7'd0, 0, 0, 0);
    chk_all("midwait_reset", 7'd0, 0, 0);
    step(0, 3'd2, 7'd0, 7'd20, 0, 0, 0);
    for (int unsigned k = 0; k < 14; k++) begin
      step(0, 3'd4, 7'd0, 7'd0, 0, 0, 0);
      chk($sformatf("rewait_hold%0d", k), State, 7'd20);
    end
    step(0, 3'd4, 7'd0, 7'd0, 0, 0, 0);
    chk_all("rewait_trap", 7'd127, 0, 1);

    // INC wraps 127 -> 0 (instance whose trap is elsewhere).
    step(1, 3'd0, 7'd0, 7'd0, 0, 0, 0);
    step(0, 3'd2, 7'd0, 7'd127, 0, 0, 0);
    chk("wrap_at127", State_w, 7'd127);
    step(0, 3'd0, 7'd0, 7'd0, 0, 0, 0);
    chk("wrap_to0", State_w, 7'd0);
    chk("wrap_timeout", {6'd0, Timeout_w}, 7'd0);
    chk("wrap_illegal", {6'd0, Illegal_w}, 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
